// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, hit encodings
// and the point values awarded for each enemy type.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] HIT_SQUID = 2'd0;
  localparam logic [1:0] HIT_CRAB  = 2'd1;
  localparam logic [1:0] HIT_OCTO  = 2'd2;
  localparam logic [1:0] HIT_UFO   = 2'd3;

  localparam int unsigned SCORE_W = 15;
  localparam int unsigned PTS_W   = 9;

  localparam logic [PTS_W-1:0] POINTS_SQUID = 9'd30;
  localparam logic [PTS_W-1:0] POINTS_CRAB  = 9'd20;
  localparam logic [PTS_W-1:0] POINTS_OCTO  = 9'd10;

  // UFO value depends on how many shots have been fired in the game (mod 16).
  localparam logic [PTS_W-1:0] UFO_TABLE [16] = '{
    9'd100, 9'd50,  9'd50,  9'd100, 9'd150, 9'd100, 9'd100, 9'd50,
    9'd300, 9'd100, 9'd100, 9'd100, 9'd50,  9'd150, 9'd100, 9'd50
  };

endpackage

// File: rtl/score_sat_add.sv
// Combinational score adder: 15-bit score plus 9-bit award, clamped so the
// result never exceeds MAX_SCORE.
module score_sat_add #(
  parameter int unsigned MAX_SCORE = 32767
) (
  input  logic [14:0] i_a,
  input  logic [8:0]  i_b,
  output logic [14:0] o_sum
);

  localparam logic [14:0] MAX15 = 15'(MAX_SCORE);

  logic [15:0] w_raw;

  always_comb begin
    w_raw = {1'b0, i_a} + {7'b0, i_b};
    o_sum = (w_raw > {1'b0, MAX15}) ? MAX15 : w_raw[14:0];
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: accumulates hit points, tracks the session high score
// and awards a single extra life at a threshold.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE     = 32767,
  parameter int unsigned EXTRA_LIFE_AT = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        fire,
  input  logic        hit_valid,
  input  logic [1:0]  hit_type,
  output logic [14:0] score,
  output logic [14:0] hi_score,
  output logic        new_hi,
  output logic        extra_life,
  output logic        playing
);

  localparam logic [14:0] LIFE_AT = 15'(EXTRA_LIFE_AT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_in_play;
  logic [8:0]  w_hit_pts;
  logic [14:0] w_sum;

  logic        r_pend_valid;
  logic [8:0]  r_pend_pts;
  logic [14:0] r_score;
  logic [14:0] r_hi_score;
  logic        r_new_hi;
  logic        r_extra_life;
  logic        r_life_given;
  logic [3:0]  r_shot_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (game_start) w_state_nxt = PLAY;
      PLAY:    if (game_over)  w_state_nxt = OVER;
      OVER:    w_state_nxt = game_start ? PLAY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_in_play = (r_state == PLAY);
  assign w_start   = game_start && !w_in_play;
  assign playing   = w_in_play;

  always_comb begin
    w_hit_pts = UFO_TABLE[r_shot_cnt];
    unique case (hit_type)
      HIT_SQUID: w_hit_pts = POINTS_SQUID;
      HIT_CRAB:  w_hit_pts = POINTS_CRAB;
      HIT_OCTO:  w_hit_pts = POINTS_OCTO;
      HIT_UFO:   w_hit_pts = UFO_TABLE[r_shot_cnt];
      default:   w_hit_pts = '0;
    endcase
  end

  // Hit is captured with its points here; the add lands one edge later, so a
  // hit arriving with game_over is still scored after the move to OVER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_pts   <= '0;
    end else begin
      r_pend_valid <= hit_valid && w_in_play;
      r_pend_pts   <= w_hit_pts;
    end
  end

  score_sat_add #(
    .MAX_SCORE(MAX_SCORE)
  ) u_sat_add (
    .i_a  (r_score),
    .i_b  (r_pend_pts),
    .o_sum(w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score      <= '0;
      r_hi_score   <= '0;
      r_new_hi     <= 1'b0;
      r_extra_life <= 1'b0;
      r_life_given <= 1'b0;
      r_shot_cnt   <= '0;
    end else if (w_start) begin
      r_score      <= '0;
      r_new_hi     <= 1'b0;
      r_extra_life <= 1'b0;
      r_life_given <= 1'b0;
      r_shot_cnt   <= '0;
    end else begin
      r_extra_life <= 1'b0;
      if (fire && w_in_play) r_shot_cnt <= r_shot_cnt + 4'd1;
      if (r_pend_valid) begin
        r_score <= w_sum;
        if (w_sum > r_hi_score) begin
          r_hi_score <= w_sum;
          r_new_hi   <= 1'b1;
        end
        if (!r_life_given && (w_sum >= LIFE_AT)) begin
          r_extra_life <= 1'b1;
          r_life_given <= 1'b1;
        end
      end
    end
  end

  assign score      = r_score;
  assign hi_score   = r_hi_score;
  assign new_hi     = r_new_hi;
  assign extra_life = r_extra_life;

endmodule

// File: tb/tb_score_keeper.sv
// Directed scoreboard bench for score_keeper: a behavioural model pushes the
// expected post-update outputs per accepted hit and they are checked on arrival.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        game_start;
  logic        game_over;
  logic        fire;
  logic        hit_valid;
  logic [1:0]  hit_type;
  logic [14:0] score;
  logic [14:0] hi_score;
  logic        new_hi;
  logic        extra_life;
  logic        playing;

  score_keeper #(
    .MAX_SCORE    (32767),
    .EXTRA_LIFE_AT(1500)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .game_start(game_start),
    .game_over (game_over),
    .fire      (fire),
    .hit_valid (hit_valid),
    .hit_type  (hit_type),
    .score     (score),
    .hi_score  (hi_score),
    .new_hi    (new_hi),
    .extra_life(extra_life),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [14:0] score;
    logic [14:0] hi;
    logic        nh;
    logic        el;
  } exp_t;

  exp_t q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cnt = 0;
  int unsigned n_el_obs = 0;
  int unsigned n_el_exp = 0;

  int m_state = 0;
  int m_shot  = 0;
  int m_score = 0;
  int m_hi    = 0;
  bit m_nh    = 1'b0;
  bit m_life  = 1'b0;

  int ufo_t [16] = '{100, 50, 50, 100, 150, 100, 100, 50,
                     300, 100, 100, 100, 50, 150, 100, 50};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_start();
    m_state = 1;
    m_score = 0;
    m_shot  = 0;
    m_nh    = 1'b0;
    m_life  = 1'b0;
  endtask

  task automatic cyc(input logic gs, input logic go, input logic f,
                     input logic hv, input logic [1:0] ht);
    exp_t e;
    int   pts;
    @(negedge clk);
    while (q.size() > 0 && q[0].due <= cnt) begin
      e = q.pop_front();
      chk("score",      32'(score),      32'(e.score));
      chk("hi_score",   32'(hi_score),   32'(e.hi));
      chk("new_hi",     32'(new_hi),     32'(e.nh));
      chk("extra_life", 32'(extra_life), 32'(e.el));
    end
    if (extra_life === 1'b1) n_el_obs++;
    game_start = gs;
    game_over  = go;
    fire       = f;
    hit_valid  = hv;
    hit_type   = ht;
    if (hv && m_state == 1) begin
      case (ht)
        2'd0:    pts = 30;
        2'd1:    pts = 20;
        2'd2:    pts = 10;
        default: pts = ufo_t[m_shot];
      endcase
      m_score = m_score + pts;
      if (m_score > 32767) m_score = 32767;
      if (m_score > m_hi) begin
        m_hi = m_score;
        m_nh = 1'b1;
      end
      e.el = 1'b0;
      if (!m_life && m_score >= 1500) begin
        m_life = 1'b1;
        e.el   = 1'b1;
        n_el_exp++;
      end
      e.due   = cnt + 2;
      e.score = 15'(m_score);
      e.hi    = 15'(m_hi);
      e.nh    = m_nh;
      q.push_back(e);
    end
    if (f && m_state == 1) m_shot = (m_shot + 1) % 16;
    case (m_state)
      0:       if (gs) model_start();
      1:       if (go) m_state = 2;
      default: if (gs) model_start(); else m_state = 0;
    endcase
    @(posedge clk);
    cnt++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic hits(input int unsigned n, input logic [1:0] ht);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, ht);
  endtask

  task automatic fires(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; game_start = 1'b0; game_over = 1'b0;
    fire = 1'b0; hit_valid = 1'b0; hit_type = 2'd0;
    #12;
    chk("rst_score",   32'(score),      32'd0);
    chk("rst_hi",      32'(hi_score),   32'd0);
    chk("rst_new_hi",  32'(new_hi),     32'd0);
    chk("rst_extra",   32'(extra_life), 32'd0);
    chk("rst_playing", 32'(playing),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    // basic hits: 30, 50, 60
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("playing_start", 32'(playing), 32'd1);
    hits(1, 2'd0); hits(1, 2'd1); hits(1, 2'd2);
    idle(3);

    // UFO table: shot 3, wrap to 0, same-cycle fire uses pre-increment
    fires(3);
    hits(1, 2'd3);
    fires(13);
    hits(1, 2'd3);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
    hits(1, 2'd3);
    idle(3);
    chk("ufo_total", 32'(score), 32'd410);

    // OVER -> PLAY directly, then extra life at 1500
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    chk("playing_over", 32'(playing), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("playing_restart", 32'(playing), 32'd1);
    chk("hi_kept", 32'(hi_score), 32'd410);
    hits(50, 2'd0);
    hits(5, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    hits(1, 2'd0);
    idle(3);
    chk("extra_count1", n_el_obs, n_el_exp);
    chk("ignored_start", 32'(score), 32'd1680);

    // saturation
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    idle(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    hits(1092, 2'd0);
    hits(1, 2'd1);
    hits(1, 2'd0);
    idle(3);
    chk("sat_score", 32'(score), 32'd32767);
    chk("extra_count2", n_el_obs, n_el_exp);

    // asynchronous reset mid-game
    #2 reset = 1'b1;
    #1;
    chk("arst_score",   32'(score),      32'd0);
    chk("arst_hi",      32'(hi_score),   32'd0);
    chk("arst_new_hi",  32'(new_hi),     32'd0);
    chk("arst_extra",   32'(extra_life), 32'd0);
    chk("arst_playing", 32'(playing),    32'd0);
    m_state = 0; m_score = 0; m_hi = 0; m_shot = 0; m_nh = 1'b0; m_life = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    hits(3, 2'd0);
    idle(3);
    chk("idle_hits_score", 32'(score), 32'd0);

    // high score across games, hit coincident with game_over
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    hits(19, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
    idle(3);
    chk("last_hit_scored", 32'(score), 32'd200);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    hits(10, 2'd2);
    idle(3);
    chk("g2_new_hi0", 32'(new_hi),   32'd0);
    chk("g2_hi200",   32'(hi_score), 32'd200);
    hits(11, 2'd2);
    idle(3);
    chk("g2_new_hi1", 32'(new_hi),   32'd1);
    chk("g2_hi210",   32'(hi_score), 32'd210);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Accumulates the player's score from hit events during play.
- Tracks the session high score and awards one extra life at a score threshold.
- Feeds the 15-bit binary score and high score to the binary-to-BCD converters that drive the HEX displays.
- Sits between the collision/game-control logic and the BCD/display path.

Parameters:
- MAX_SCORE, 32767, saturation ceiling; must fit the 15-bit score width.
- EXTRA_LIFE_AT, 1500, score at which the single extra life is awarded.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high; all state cleared immediately
- game_start  input  1  one-cycle pulse; begins a new game
- game_over  input  1  one-cycle pulse; ends the current game
- fire  input  1  one-cycle pulse per player shot
- hit_valid  input  1  one-cycle pulse; one enemy destroyed this cycle
- hit_type  input  2  0 = squid, 1 = crab, 2 = octopus, 3 = UFO
- score  output  15  current score, registered
- hi_score  output  15  session high score, registered
- new_hi  output  1  level; current game has exceeded the high score held at game start
- extra_life  output  1  one-cycle pulse when the score first reaches EXTRA_LIFE_AT
- playing  output  1  high while in PLAY

Behaviour:
- Reset values: score = 0, hi_score = 0, new_hi = 0, extra_life = 0, playing = 0, state = IDLE, shot_cnt = 0, life_given = 0.
- Reset is asynchronous and active-high.
- States: IDLE, PLAY, OVER.
  - IDLE -> PLAY on game_start.
  - PLAY -> OVER on game_over.
  - OVER -> PLAY on game_start.
  - OVER -> IDLE after exactly one cycle when game_start is absent.
  - game_start in PLAY is ignored.
- Entering PLAY from game_start clears score, shot_cnt, new_hi and life_given in that same edge. hi_score is not cleared.
- Point values:
  - type 0 = 30, type 1 = 20, type 2 = 10.
  - type 3 = UFO_TABLE[shot_cnt], where UFO_TABLE = 100, 50, 50, 100, 150, 100, 100, 50, 300, 100, 100, 100, 50, 150, 100, 50.
- shot_cnt:
  - 4-bit; increments on fire in PLAY only; wraps 15 -> 0.
  - When fire and a UFO hit occur in the same cycle, the UFO lookup uses the pre-increment shot_cnt.
- Add path, registered with one-cycle latency: hit_valid at edge N -> updated score visible after edge N+1.
  - Hits outside PLAY are ignored.
  - Sum is computed 16 bits wide; if it exceeds MAX_SCORE, score = MAX_SCORE (saturate, never wrap).
- extra_life:
  - Pulses for exactly one cycle, coincident with the score update that makes score >= EXTRA_LIFE_AT while life_given = 0.
  - That update sets life_given = 1; there is no second award.
- High score:
  - hi_score updates in the same cycle as score whenever the new score > hi_score. It therefore tracks live and never decreases.
  - new_hi sets on the first such update in a game and holds until the next game_start or reset.
- game_over and hit_valid in the same cycle: the hit is still scored, and PLAY -> OVER takes effect on that edge.
- Reset mid-game clears everything, including hi_score.

Decomposition:
- Package score_pkg holds:
  - state enum;
  - POINTS_SQUID/CRAB/OCTO constants;
  - 16-entry UFO_TABLE constant array;
  - hit_type encoding constants.
- Sub-module score_sat_add (15-bit + 9-bit add with clamp to MAX_SCORE) is purely combinational and instantiated once.

Test Plan:
- reset, game_start, then hit_valid with types 0, 1, 2 on consecutive cycles -> score reads 30, 50, 60 one cycle after each hit; hi_score follows; new_hi = 1.
- 3 fire pulses then UFO hit (shot_cnt = 3) -> +100; 16 fires wrap shot_cnt to 0; then UFO hit -> +100 from table entry 0.
- 50 squid hits (1500 points) -> extra_life pulses exactly once at the 50th update; further hits produce no pulse.
- Drive score near the ceiling (1092 squid hits = 32760, then one crab hit) -> score = 32767 saturated; a further hit leaves 32767.
- Game scoring 200, game_over, game_start, score 100 -> hi_score stays 200 and new_hi = 0; after 110 more points new_hi = 1 and hi_score = 210.
- Reset asserted mid-game between clock edges -> all outputs 0 immediately, without waiting for a clock edge; hits before the next game_start are ignored.
